// File: rtl/mult_wb_pkg.sv
// ---------------------------------------------------------------------------
// mult_wb_pkg
// Shared types and helpers for the multiplier writeback buffer.
//   mult_wb_entry_t : one buffered result, transaction ID above the result
//   cnt_width()     : width of an occupancy counter that can hold 0..depth
// ---------------------------------------------------------------------------
package mult_wb_pkg;

  localparam int MULT_WB_WIDTH   = 32;
  localparam int MULT_WB_ID_BITS = 5;

  typedef struct packed {
    logic [MULT_WB_ID_BITS-1:0] trans_id;
    logic [MULT_WB_WIDTH-1:0]   result;
  } mult_wb_entry_t;

  // An occupancy counter must reach depth itself, not just depth-1, hence +1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mult_result_fifo_mem.sv
// ---------------------------------------------------------------------------
// mult_result_fifo_mem
// Plain DEPTH x ENTRY_W register array backing the result FIFO. It holds no
// control logic; the owner decides when and where to write.
// Ports:
//   clk_i, rst_i : clock, async active-high reset (clears every entry to 0)
//   i_we         : write enable
//   i_waddr      : write address
//   i_wdata      : write data
//   i_raddr      : read address
//   o_rdata      : combinational read data at i_raddr
// ---------------------------------------------------------------------------
module mult_result_fifo_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 37,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  // Storage is cleared on reset so the head outputs read as zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mult_result_buffer.sv
// ---------------------------------------------------------------------------
// mult_result_buffer
// First-word-fall-through buffer between the single-cycle pipelined
// multiplier and the writeback arbiter. Because the multiplier cannot be
// stalled, the buffer hands out a credit-style ready to the issue stage that
// counts both stored entries and the one result that may still be in flight.
// Ports:
//   clk_i, rst_i       : clock, async active-high reset
//   flush_i            : discard all buffered and in-flight results
//   issue_valid_i      : issue stage offers a multiply-class op
//   mult_ready_o       : issue permitted this cycle
//   mult_valid_i       : multiplier result valid
//   mult_trans_id_i    : multiplier result transaction ID
//   mult_result_i      : multiplier result data
//   wb_valid_o         : head entry valid
//   wb_trans_id_o      : head entry transaction ID
//   wb_result_o        : head entry result
//   wb_ready_i         : writeback consumes the head entry
//   count_o            : current occupancy
//   overflow_o         : sticky, a push arrived with no space
// ---------------------------------------------------------------------------
module mult_result_buffer
  import mult_wb_pkg::*;
#(
  parameter int WIDTH   = MULT_WB_WIDTH,
  parameter int ID_BITS = MULT_WB_ID_BITS,
  parameter int DEPTH   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  output logic                        mult_ready_o,
  input  logic                        mult_valid_i,
  input  logic [ID_BITS-1:0]          mult_trans_id_i,
  input  logic [WIDTH-1:0]            mult_result_i,
  output logic                        wb_valid_o,
  output logic [ID_BITS-1:0]          wb_trans_id_o,
  output logic [WIDTH-1:0]            wb_result_o,
  input  logic                        wb_ready_i,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        overflow_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int ENTRY_W = ID_BITS + WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic               r_inflight;
  logic               r_overflow;

  logic               w_pushReq;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_dropped;
  logic [CNT_W:0]     w_credit;
  logic [ENTRY_W-1:0] w_wrData;
  logic [ENTRY_W-1:0] w_rdData;

  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = (r_count != '0) && wb_ready_i;
  assign w_pushReq = mult_valid_i && !flush_i;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign w_push    = w_pushReq && (!w_full || w_pop);
  assign w_dropped = w_pushReq && w_full && !w_pop;

  // Credit ignores a same-cycle pop on purpose: that keeps wb_ready_i out of
  // the combinational path to the issue stage.
  assign w_credit     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign mult_ready_o = !flush_i && (w_credit < {1'b0, DEPTH_C});

  // Pointers, occupancy and the in-flight marker. Flush clears them on the
  // next edge; a pop in the flush cycle is simply absorbed by the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_inflight <= 1'b0;
    end else if (flush_i) begin
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= issue_valid_i && mult_ready_o;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Overflow is an error flag for debug; only reset clears it, not flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
    end else if (w_dropped) begin
      r_overflow <= 1'b1;
    end
  end

  assign w_wrData = {mult_trans_id_i, mult_result_i};

  mult_result_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_push),
    .i_waddr (r_wrPtr),
    .i_wdata (w_wrData),
    .i_raddr (r_rdPtr),
    .o_rdata (w_rdData)
  );

  assign wb_valid_o                   = (r_count != '0);
  assign {wb_trans_id_o, wb_result_o} = w_rdData;
  assign count_o                      = r_count;
  assign overflow_o                   = r_overflow;

endmodule

// File: tb/tb_mult_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_mult_result_buffer
// Directed bench for mult_result_buffer at WIDTH=32, ID_BITS=5, DEPTH=4.
// Each step drives inputs just after a rising edge, lets them settle, then
// compares outputs before the next edge. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_mult_result_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        issueValid;
  logic        multReady;
  logic        multValid;
  logic [4:0]  multTransId;
  logic [31:0] multResult;
  logic        wbValid;
  logic [4:0]  wbTransId;
  logic [31:0] wbResult;
  logic        wbReady;
  logic [2:0]  count;
  logic        overflow;

  int assertCount = 0;
  int failCount   = 0;

  mult_result_buffer #(
    .WIDTH   (32),
    .ID_BITS (5),
    .DEPTH   (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .issue_valid_i   (issueValid),
    .mult_ready_o    (multReady),
    .mult_valid_i    (multValid),
    .mult_trans_id_i (multTransId),
    .mult_result_i   (multResult),
    .wb_valid_o      (wbValid),
    .wb_trans_id_o   (wbTransId),
    .wb_result_o     (wbResult),
    .wb_ready_i      (wbReady),
    .count_o         (count),
    .overflow_o      (overflow)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs for the current cycle and let combinational outputs settle.
  task automatic applyStimulus(input logic issue, input logic mValid,
                               input logic [4:0] id, input logic [31:0] res,
                               input logic ready, input logic fl);
    issueValid  = issue;
    multValid   = mValid;
    multTransId = id;
    multResult  = res;
    wbReady     = ready;
    flush       = fl;
    #1;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic expReady [6];
    expReady = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // ---- reset values ----
    rst = 1'b1;
    issueValid = 0; multValid = 0; multTransId = '0; multResult = '0;
    wbReady = 0; flush = 0;
    #1;
    checkOutput("rst_wb_valid", 32'(wbValid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_mult_ready", 32'(multReady), 32'd1);
    checkOutput("rst_wb_id", 32'(wbTransId), 32'd0);
    checkOutput("rst_wb_result", wbResult, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // ---- single op: issue c0, result c1, visible c2, gone c3 ----
    applyStimulus(1, 0, 5'd0, 32'd0, 1, 0);
    checkOutput("single_ready_c0", 32'(multReady), 32'd1);
    tick();
    applyStimulus(0, 1, 5'd3, 32'h0000_0015, 1, 0);
    checkOutput("single_no_bypass_c1", 32'(wbValid), 32'd0);
    checkOutput("single_ready_c1", 32'(multReady), 32'd1);
    tick();
    applyStimulus(0, 0, 5'd0, 32'd0, 1, 0);
    checkOutput("single_wb_valid_c2", 32'(wbValid), 32'd1);
    checkOutput("single_wb_id_c2", 32'(wbTransId), 32'd3);
    checkOutput("single_wb_result_c2", wbResult, 32'h0000_0015);
    checkOutput("single_count_c2", 32'(count), 32'd1);
    tick();
    checkOutput("single_count_c3", 32'(count), 32'd0);
    checkOutput("single_wb_valid_c3", 32'(wbValid), 32'd0);

    // ---- backpressure fill: ids 1..4 arrive one cycle after each accept ----
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, (c >= 1 && c <= 4), 5'(c), 32'h100 + 32'(c), 0, 0);
      checkOutput($sformatf("fill_ready_c%0d", c), 32'(multReady), 32'(expReady[c]));
      tick();
    end

    // ---- drain in order, ready recovers after the first pop ----
    applyStimulus(0, 0, 5'd0, 32'd0, 1, 0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_overflow", 32'(overflow), 32'd0);
    checkOutput("full_ready", 32'(multReady), 32'd0);
    checkOutput("drain_id1", 32'(wbTransId), 32'd1);
    checkOutput("drain_res1", wbResult, 32'h101);
    tick();
    checkOutput("drain_ready_after_pop", 32'(multReady), 32'd1);
    checkOutput("drain_count3", 32'(count), 32'd3);
    checkOutput("drain_id2", 32'(wbTransId), 32'd2);
    tick();
    checkOutput("drain_id3", 32'(wbTransId), 32'd3);
    tick();
    checkOutput("drain_id4", 32'(wbTransId), 32'd4);
    checkOutput("drain_res4", wbResult, 32'h104);
    tick();
    checkOutput("drain_empty_valid", 32'(wbValid), 32'd0);
    checkOutput("drain_empty_count", 32'(count), 32'd0);

    // ---- full with simultaneous push and pop ----
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 5'(5 + k), 32'hA5A5_0000 + 32'(5 + k), 0, 0);
      tick();
    end
    applyStimulus(0, 1, 5'd9, 32'hA5A5_0009, 1, 0);
    checkOutput("pp_count_before", 32'(count), 32'd4);
    checkOutput("pp_head_id5", 32'(wbTransId), 32'd5);
    tick();
    applyStimulus(0, 0, 5'd0, 32'd0, 1, 0);
    checkOutput("pp_count_after", 32'(count), 32'd4);
    checkOutput("pp_overflow", 32'(overflow), 32'd0);
    checkOutput("pp_id6", 32'(wbTransId), 32'd6);
    tick();
    checkOutput("pp_id7", 32'(wbTransId), 32'd7);
    tick();
    checkOutput("pp_id8", 32'(wbTransId), 32'd8);
    tick();
    checkOutput("pp_id9_last", 32'(wbTransId), 32'd9);
    checkOutput("pp_res9_last", wbResult, 32'hA5A5_0009);
    tick();
    checkOutput("pp_empty", 32'(count), 32'd0);

    // ---- full with push and no pop: drop and sticky overflow ----
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 5'(10 + k), 32'hB000_0000 + 32'(10 + k), 0, 0);
      tick();
    end
    applyStimulus(0, 1, 5'd14, 32'hB000_000E, 0, 0);
    checkOutput("ovf_before", 32'(overflow), 32'd0);
    tick();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 0);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd4);
    checkOutput("ovf_head_id10", 32'(wbTransId), 32'd10);
    tick();
    tick();
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(0, 0, 5'd0, 32'd0, 1, 0);
    checkOutput("ovf_drain_id10", 32'(wbTransId), 32'd10);
    tick();
    checkOutput("ovf_drain_id11", 32'(wbTransId), 32'd11);
    tick();
    checkOutput("ovf_drain_id12", 32'(wbTransId), 32'd12);
    tick();
    checkOutput("ovf_drain_id13", 32'(wbTransId), 32'd13);
    tick();
    checkOutput("ovf_dropped_absent", 32'(wbValid), 32'd0);
    checkOutput("ovf_sticky_after_drain", 32'(overflow), 32'd1);

    // ---- flush with two buffered and one arriving result ----
    applyStimulus(0, 1, 5'd20, 32'hC000_0014, 0, 0);
    tick();
    applyStimulus(0, 1, 5'd21, 32'hC000_0015, 0, 0);
    tick();
    applyStimulus(1, 1, 5'd22, 32'hC000_0016, 0, 1);
    checkOutput("flush_ready_low", 32'(multReady), 32'd0);
    checkOutput("flush_count_before", 32'(count), 32'd2);
    tick();
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 0);
    checkOutput("flush_wb_valid", 32'(wbValid), 32'd0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_ready", 32'(multReady), 32'd1);
    checkOutput("flush_keeps_overflow", 32'(overflow), 32'd1);
    tick();
    checkOutput("flush_no_ghost", 32'(wbValid), 32'd0);

    // ---- asynchronous reset with three entries ----
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 5'(1 + k), 32'hD000_0000 + 32'(1 + k), 0, 0);
      tick();
    end
    applyStimulus(0, 0, 5'd0, 32'd0, 0, 0);
    checkOutput("arst_count_before", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_wb_valid", 32'(wbValid), 32'd0);
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_overflow", 32'(overflow), 32'd0);
    checkOutput("arst_wb_id", 32'(wbTransId), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("arst_ready_after", 32'(multReady), 32'd1);
    checkOutput("arst_valid_after", 32'(wbValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
